// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to APB master bridge.
// Converts single AHB transfers into two-phase APB transfers (SETUP, ENABLE).
// Each slave owns a 4 KB window selected by a 4-bit index in haddr. Unmapped
// indices get the two-cycle AHB ERROR response.
//
// Handshake: an AHB address phase is taken when hsel & hready & htrans[1]
// while the bridge is able to start a transfer (IDLE, ENABLE or ERR2). The
// data phase completes on the cycle the bridge drives hreadyout=1. The APB
// side follows the standard SETUP (psel=1, penable=0) then ENABLE
// (psel=1, penable=1) sequence with zero APB wait states.
//
// dbg_state exposes the FSM state: 0=IDLE 1=SETUP 2=ENABLE 3=ERR1 4=ERR2.
module ahb2apb_bridge #(
    parameter int NSLV    = 8,
    parameter int SLV_LSB = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    // AHB-Lite slave side
    input  logic            hsel,
    input  logic [31:0]     haddr,
    input  logic [1:0]      htrans,
    input  logic            hwrite,
    input  logic [2:0]      hsize,
    input  logic [31:0]     hwdata,
    input  logic            hready,
    output logic            hreadyout,
    output logic            hresp,
    output logic [31:0]     hrdata,
    // APB master side
    output logic [31:0]     paddr,
    output logic [NSLV-1:0] psel,
    output logic            penable,
    output logic            pwrite,
    output logic [31:0]     pwdata,
    input  logic [31:0]     prdata,
    // FSM state for observation
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ENABLE = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] pwdata_q, pwdata_d;

    logic        accept;
    logic [3:0]  idx_in;
    logic        mapped_in;
    logic        take_addr;
    logic        sel_active;

    // Every access is a 32-bit word, so the transfer size carries no information.
    logic        unused_hsize;
    assign unused_hsize = ^hsize;

    assign accept    = hsel & hready & htrans[1];
    assign idx_in    = haddr[SLV_LSB+3:SLV_LSB];
    assign mapped_in = (32'(idx_in) < 32'(NSLV));

    // State and APB-side registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            pwdata_q <= pwdata_d;
        end
    end

    // Next-state logic and AHB response outputs.
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        idx_d      = idx_q;
        pwdata_d   = pwdata_q;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        penable    = 1'b0;
        sel_active = 1'b0;
        take_addr  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                take_addr = 1'b1;
            end
            S_SETUP: begin
                hreadyout  = 1'b0;
                sel_active = 1'b1;
                // hwdata is valid during this data-phase cycle; hold it for ENABLE.
                pwdata_d   = hwdata;
                state_d    = S_ENABLE;
            end
            S_ENABLE: begin
                sel_active = 1'b1;
                penable    = 1'b1;
                take_addr  = 1'b1;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp     = 1'b1;
                take_addr = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // States that end a data phase can take the next address phase directly.
        if (take_addr) begin
            state_d = S_IDLE;
            if (accept) begin
                if (mapped_in) begin
                    // APB address/direction only move for transfers that reach
                    // the APB bus, so error responses leave them untouched.
                    state_d  = S_SETUP;
                    paddr_d  = haddr;
                    pwrite_d = hwrite;
                    idx_d    = idx_in;
                end else begin
                    state_d = S_ERR1;
                end
            end
        end
    end

    // One-hot slave select, asserted for the whole SETUP/ENABLE pair.
    always_comb begin
        psel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_active && (idx_q == 4'(i))) begin
                psel[i] = 1'b1;
            end
        end
    end

    // Write data passes straight through in SETUP, then comes from the register.
    always_comb begin
        pwdata = (state_q == S_SETUP) ? hwdata : pwdata_q;
    end

    // Read data is only forwarded during a read ENABLE cycle.
    always_comb begin
        hrdata = '0;
        if ((state_q == S_ENABLE) && !pwrite_q) begin
            hrdata = prdata;
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: randomized AHB traffic against a transaction-level model.
// Each accepted AHB transfer pushes its expected data-phase cycles into a
// queue; every cycle pops one entry (or expects idle) and compares all outputs.
module tb_ahb2apb_bridge;

    localparam int NSLV = 8;

    // Data-phase cycle kinds: 0 idle, 1 setup, 2 enable, 3 err1, 4 err2.
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
    } rec_t;

    logic            clk;
    logic            rst_n;
    logic            hsel;
    logic [31:0]     haddr;
    logic [1:0]      htrans;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [31:0]     hwdata;
    logic            hready;
    logic            hreadyout;
    logic            hresp;
    logic [31:0]     hrdata;
    logic [31:0]     paddr;
    logic [NSLV-1:0] psel;
    logic            penable;
    logic            pwrite;
    logic [31:0]     pwdata;
    logic [31:0]     prdata;
    logic [2:0]      dbg_state;

    rec_t            exp_q[$];
    logic [31:0]     slave_mem [NSLV][16];
    logic [31:0]     ref_mem   [NSLV][16];
    int              n_vec;
    int              n_fail;

    ahb2apb_bridge #(.NSLV(NSLV), .SLV_LSB(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // APB slaves: write on the closing edge of ENABLE, OR-combined read data.
    always @(posedge clk) begin
        if (rst_n && penable && pwrite) begin
            for (int i = 0; i < NSLV; i++) begin
                if (psel[i]) slave_mem[i][paddr[5:2]] <= pwdata;
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (penable && !pwrite) begin
            for (int i = 0; i < NSLV; i++) begin
                if (psel[i]) prdata = prdata | slave_mem[i][paddr[5:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive data phase from the model, offer an address phase,
    // then compare every output against the expected cycle kind.
    task automatic step(input logic s_hsel, input logic [1:0] s_trans,
                        input logic [31:0] s_addr, input logic s_write,
                        input logic [31:0] s_wdata, input logic s_hready);
        rec_t        r;
        bit          in_dp;
        logic [3:0]  idx;
        logic [7:0]  e_psel;
        logic [31:0] e_rd;
        @(negedge clk);
        in_dp = (exp_q.size() > 0);
        if (in_dp) r = exp_q.pop_front();
        else begin
            r.kind = 0; r.addr = '0; r.wr = 1'b0; r.wd = '0;
        end
        hwdata = in_dp ? r.wd : $urandom();
        if (in_dp) hready = (r.kind == 1 || r.kind == 3) ? 1'b0 : 1'b1;
        else       hready = s_hready;
        hsel   = s_hsel;
        htrans = s_trans;
        haddr  = s_addr;
        hwrite = s_write;
        hsize  = 3'($urandom_range(0, 7));
        if (s_hsel && hready && s_trans[1]) begin
            idx = s_addr[15:12];
            if (int'(idx) < NSLV) begin
                exp_q.push_back('{1, s_addr, s_write, s_wdata});
                exp_q.push_back('{2, s_addr, s_write, s_wdata});
            end else begin
                exp_q.push_back('{3, s_addr, s_write, s_wdata});
                exp_q.push_back('{4, s_addr, s_write, s_wdata});
            end
        end
        #1;
        e_psel = '0;
        e_rd   = '0;
        if (r.kind == 1 || r.kind == 2) e_psel = 8'b1 << r.addr[15:12];
        if (r.kind == 2 && !r.wr) e_rd = ref_mem[r.addr[14:12]][r.addr[5:2]];
        chk("hreadyout", 32'(hreadyout), 32'((r.kind == 1 || r.kind == 3) ? 1 : 0) ^ 32'd1);
        chk("hresp",     32'(hresp),     32'((r.kind == 3 || r.kind == 4) ? 1 : 0));
        chk("psel",      32'(psel),      32'(e_psel));
        chk("penable",   32'(penable),   32'((r.kind == 2) ? 1 : 0));
        chk("hrdata",    hrdata,         e_rd);
        chk("state",     32'(dbg_state), 32'(r.kind));
        if (r.kind == 1 || r.kind == 2) begin
            chk("paddr",  paddr,          r.addr);
            chk("pwrite", 32'(pwrite),    32'(r.wr));
            chk("pwdata", pwdata,         r.wd);
        end
        if (r.kind == 2 && r.wr) ref_mem[r.addr[14:12]][r.addr[5:2]] = r.wd;
    endtask

    task automatic idle_step();
        step(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    // Main sequence
    initial begin
        logic [31:0] a;
        logic [31:0] up;
        n_vec  = 0;
        n_fail = 0;
        for (int i = 0; i < NSLV; i++) begin
            for (int j = 0; j < 16; j++) begin
                slave_mem[i][j] = $urandom();
                ref_mem[i][j]   = slave_mem[i][j];
            end
        end
        slave_mem[2][2] = 32'hA5A5_5A5A;
        ref_mem[2][2]   = 32'hA5A5_5A5A;
        hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hwdata = '0; hready = 1'b1;

        // Reset values
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp",     32'(hresp),     32'd0);
        chk("rst_hrdata",    hrdata,         32'd0);
        chk("rst_psel",      32'(psel),      32'd0);
        chk("rst_penable",   32'(penable),   32'd0);
        chk("rst_pwrite",    32'(pwrite),    32'd0);
        chk("rst_paddr",     paddr,          32'd0);
        chk("rst_pwdata",    pwdata,         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // GPIO write at slave 0, then read back
        step(1'b1, 2'b10, 32'h0000_0004, 1'b1, 32'h0000_00FF, 1'b1);
        chk("wr_addr_hreadyout", 32'(hreadyout), 32'd1);
        idle_step();
        chk("wr_setup_psel",    32'(psel),      32'h01);
        chk("wr_setup_penable", 32'(penable),   32'd0);
        chk("wr_setup_hready",  32'(hreadyout), 32'd0);
        idle_step();
        chk("wr_en_pwdata", pwdata,         32'h0000_00FF);
        chk("wr_en_hready", 32'(hreadyout), 32'd1);
        step(1'b1, 2'b10, 32'h0000_0004, 1'b0, 32'h0, 1'b1);
        idle_step();
        idle_step();
        chk("rd_back_hrdata", hrdata, 32'h0000_00FF);

        // Read at slave 2
        step(1'b1, 2'b10, 32'h0000_2008, 1'b0, 32'h0, 1'b1);
        idle_step();
        idle_step();
        chk("rd2_psel",   32'(psel),      32'h04);
        chk("rd2_hrdata", hrdata,         32'hA5A5_5A5A);
        chk("rd2_hready", 32'(hreadyout), 32'd1);

        // Back-to-back write then read
        step(1'b1, 2'b10, 32'h0000_1000, 1'b1, 32'h1234_5678, 1'b1);
        idle_step();
        chk("b2b_st0", 32'(dbg_state), 32'd1);
        step(1'b1, 2'b10, 32'h0000_1004, 1'b0, 32'h0, 1'b1);
        chk("b2b_st1", 32'(dbg_state), 32'd2);
        idle_step();
        chk("b2b_st2",   32'(dbg_state), 32'd1);
        chk("b2b_paddr", paddr,          32'h0000_1004);
        idle_step();
        chk("b2b_st3", 32'(dbg_state), 32'd2);

        // Unmapped write
        step(1'b1, 2'b10, 32'h0000_9000, 1'b1, 32'hDEAD_BEEF, 1'b1);
        idle_step();
        chk("err1_hready", 32'(hreadyout), 32'd0);
        chk("err1_hresp",  32'(hresp),     32'd1);
        chk("err1_psel",   32'(psel),      32'd0);
        idle_step();
        chk("err2_hready", 32'(hreadyout), 32'd1);
        chk("err2_hresp",  32'(hresp),     32'd1);
        chk("err2_psel",   32'(psel),      32'd0);

        // IDLE, BUSY and NONSEQ-with-hready-low are not accepted
        step(1'b1, 2'b00, 32'h0000_0004, 1'b1, 32'h0, 1'b1);
        step(1'b1, 2'b01, 32'h0000_0004, 1'b1, 32'h0, 1'b1);
        step(1'b1, 2'b10, 32'h0000_0004, 1'b1, 32'h0, 1'b0);
        idle_step();
        chk("nacc_state",  32'(dbg_state), 32'd0);
        chk("nacc_hready", 32'(hreadyout), 32'd1);
        chk("nacc_hresp",  32'(hresp),     32'd0);
        chk("nacc_psel",   32'(psel),      32'd0);

        // Reset during SETUP of a write aborts it
        step(1'b1, 2'b10, 32'h0000_3000, 1'b1, 32'h1111_1111, 1'b1);
        idle_step();
        idle_step();
        step(1'b1, 2'b10, 32'h0000_3000, 1'b1, 32'h2222_2222, 1'b1);
        idle_step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_psel",    32'(psel),      32'd0);
        chk("arst_penable", 32'(penable),   32'd0);
        chk("arst_hrdata",  hrdata,         32'd0);
        chk("arst_hready",  32'(hreadyout), 32'd1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b10, 32'h0000_3000, 1'b0, 32'h0, 1'b1);
        idle_step();
        idle_step();
        chk("arst_keep", hrdata, 32'h1111_1111);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            up = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_0000) : 32'h0;
            a  = up | (32'($urandom_range(0, 11)) << 12)
                    | (32'($urandom_range(0, 63)) << 6)
                    | (32'($urandom_range(0, 15)) << 2);
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a,
                 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 4) != 0));
        end
        repeat (3) idle_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

AHB-Lite slave to APB master bridge for the peripheral subsystem. It converts single AHB transfers from the core bus into two-phase APB transfers (SETUP, ENABLE) and drives the peripheral slaves, including apbgpio. It decodes one select line per peripheral and returns OR-combined read data to AHB. Unmapped addresses receive the standard two-cycle AHB ERROR response.

## Interface
Parameters:
- NSLV, 8: number of APB slaves (1..16); one psel bit each.
- SLV_LSB, 12: LSB of the 4-bit slave-index field in haddr; each slave gets a 4 KB window.

Ports:
- clk  input  1  single bus clock shared by AHB and APB.
- rst_n  input  1  asynchronous, active-low reset.
- hsel  input  1  AHB slave select from the AHB decoder.
- haddr  input  32  AHB address.
- htrans  input  2  AHB transfer type; NONSEQ and SEQ start a transfer.
- hwrite  input  1  1 = write.
- hsize  input  3  ignored; every access is treated as a 32-bit word.
- hwdata  input  32  write data, valid in the AHB data phase.
- hready  input  1  bus-wide HREADY.
- hreadyout  output  1  bridge ready.
- hresp  output  1  0 = OKAY, 1 = ERROR.
- hrdata  output  32  read data.
- paddr  output  32  APB address, registered.
- psel  output  NSLV  one-hot slave select.
- penable  output  1  APB enable phase.
- pwrite  output  1  APB direction.
- pwdata  output  32  APB write data, registered.
- prdata  input  32  OR of all slave prdata. Every slave drives 0 when it is not in a selected read ENABLE phase.

## Operation
- Accept condition: hsel & hready & htrans[1]. When it holds, latch haddr, hwrite and the slave index idx = haddr[SLV_LSB+3:SLV_LSB].
- FSM states: IDLE, SETUP, ENABLE, ERR1, ERR2.
- IDLE:
  - Accept with idx < NSLV goes to SETUP.
  - Accept with idx >= NSLV goes to ERR1.
  - Otherwise stay in IDLE.
- SETUP (one cycle):
  - psel[idx]=1, penable=0, hreadyout=0.
  - paddr and pwrite hold the latched values.
  - pwdata is loaded from hwdata on entry to this state, that is, at the end of the AHB address phase plus one cycle: hwdata is sampled on the clock edge that leaves the first data-phase cycle. Concretely, pwdata is registered on the SETUP cycle itself and driven stably through ENABLE. Implementation: register hwdata at the SETUP-to-ENABLE edge, and drive pwdata combinationally from hwdata during SETUP.
  - Always go to ENABLE.
- ENABLE (one cycle):
  - psel[idx]=1, penable=1, hreadyout=1, hresp=0.
  - hrdata = prdata, passed through combinationally. hrdata is 0 on writes.
  - The slave performs its write at the end of this cycle.
  - A new accept in this cycle goes to SETUP (mapped) or ERR1 (unmapped), with no idle cycle in between. Otherwise go to IDLE.
- ERR1: hreadyout=0, hresp=1, no psel. Go to ERR2.
- ERR2: hreadyout=1, hresp=1. The master's next address phase is honoured exactly as in IDLE.
- IDLE/BUSY transfers, or hsel=0: the bridge stays in IDLE with hreadyout=1 and hresp=0, which is a zero-wait OKAY.
- Outside SETUP and ENABLE: psel=0, penable=0, hrdata=0.

## Timing
- Reset values (immediate, asynchronous):
  - state=IDLE.
  - hreadyout=1, hresp=0, hrdata=0.
  - psel=0, penable=0, pwrite=0.
  - paddr=0, pwdata=0.
- Latency per mapped transfer:
  - 1 address-phase cycle, then a 2-cycle data phase (1 wait state).
  - Back-to-back throughput is one transfer per 2 cycles.
- APB signals (paddr, pwrite, psel, pwdata) are stable across SETUP and ENABLE. They may change only on leaving ENABLE.
- Reset asserted mid-transfer aborts the transfer. No APB write completes unless the ENABLE cycle's closing edge occurs with rst_n high.
- hready low while the bridge is in IDLE (another slave is inserting wait states): the address is not accepted.

## Test plan
- Write to GPIO at slave 0:
  - Stimulus: NONSEQ write, haddr=0x0000_0004, hwdata=0x0000_00FF.
  - Required: SETUP with psel=0x01, penable=0; then ENABLE with pwdata=0xFF, hreadyout=1.
  - Check: a subsequent read of 0x04 returns 0xFF.
- Read at slave 2:
  - Stimulus: read haddr=0x0000_2008, with the bench slave driving prdata=0xA5A5_5A5A in ENABLE.
  - Required: psel=0x04, and hrdata=0xA5A5_5A5A with hreadyout=1 in that same cycle.
- Back-to-back pipelining:
  - Stimulus: write 0x1000 followed immediately by read 0x1004.
  - Required: SETUP, ENABLE, SETUP, ENABLE with no IDLE cycle, the second paddr=0x1004, and a total of 4 data cycles.
- Unmapped address with NSLV=8:
  - Stimulus: write haddr=0x0000_9000.
  - Required: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1).
  - Required: psel stays 0 throughout.
- Idle/BUSY and hready low:
  - Stimulus: htrans=IDLE, BUSY and NONSEQ each with hready=0.
  - Required: state stays IDLE, hreadyout=1, hresp=0, psel=0.
- Reset during SETUP of a write:
  - Stimulus: assert rst_n=0.
  - Required: psel, penable and hrdata go to 0 and hreadyout goes to 1 immediately.
  - Required: the target register is unchanged after release.
